// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter for fetch/data; grant same cycle, read data MEM_LATENCY cycles later, losers stall.
// Define ARB_STARVE_GUARD_EN to promote fetch after STARVE_LIMIT denied arbitration cycles.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

    state_t     state_q, state_d;
    logic [2:0] lat_q, lat_d;
    logic       arb_cycle;
    logic       if_prio;
    logic       if_win, d_win;

    // Arbitration is open when idle or when the outstanding read returns this cycle.
    assign arb_cycle = (state_q == IDLE) || (lat_q == 3'd0);
    assign if_win    = if_req && (!d_req || if_prio);
    assign d_win     = d_req && !if_win;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q;

    assign if_prio = (starve_q == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else if (!if_req || if_gnt) begin
            starve_q <= 4'd0;
        end else if (arb_cycle && starve_q != LIMIT) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    logic unused_starve_limit;

    assign if_prio             = 1'b0;
    assign unused_starve_limit = (STARVE_LIMIT > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        if (state_q != IDLE && lat_q != 3'd0) begin
            lat_d = lat_q - 3'd1;
        end else if (if_gnt) begin
            state_d = RD_IF;
            lat_d   = LAT_INIT;
        end else if (d_gnt && !d_we) begin
            state_d = RD_D;
            lat_d   = LAT_INIT;
        end else begin
            state_d = IDLE;
            lat_d   = 3'd0;
        end
    end

    // Every output is gated by reset so nothing leaks while reset is held.
    always_comb begin
        if_gnt    = !reset && arb_cycle && if_win;
        d_gnt     = !reset && arb_cycle && d_win;
        if_rvalid = !reset && (state_q == RD_IF) && (lat_q == 3'd0);
        d_rvalid  = !reset && (state_q == RD_D) && (lat_q == 3'd0);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a latency-1 instance with a memory model and a latency-3 instance for reset mid-read.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic        mem_en, mem_we;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        reset3, if_req3, if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3;
    logic [31:0] if_addr3, if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic        d_req3 = 1'b0, d_we3 = 1'b0;
    logic [31:0] d_addr3 = '0, d_wdata3 = '0;
    localparam logic [31:0] MEM3_DATA = 32'h5A5A_1234;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .reset(reset3),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(MEM3_DATA)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    logic [31:0] rd_q = '0;
    logic [63:0] if_q [$];
    logic [63:0] d_q [$];

    assign mem_rdata = rd_q;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: writes land at the edge, read data appears the cycle after enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
            else        rd_q <= mem_arr[mem_addr[9:2]];
        end
    end

    // Scoreboard: grants push the expected {cycle, data}; rvalids pop and compare.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset) begin
            check("gnt_excl", {63'd0, if_gnt & d_gnt}, 64'd0);
            if (if_gnt) if_q.push_back({32'(cyc + 1), ref_mem[if_addr[9:2]]});
            if (d_gnt) begin
                if (d_we) ref_mem[d_addr[9:2]] = d_wdata;
                else      d_q.push_back({32'(cyc + 1), ref_mem[d_addr[9:2]]});
            end
            if (if_rvalid) begin
                if (if_q.size() == 0) check("if_unexpected", 64'(if_q.size()), 64'd1);
                else begin
                    e = if_q.pop_front();
                    check("if_resp", {32'(cyc), if_rdata}, e);
                end
            end else check("if_rdata_idle", {32'd0, if_rdata}, 64'd0);
            if (d_rvalid) begin
                if (d_q.size() == 0) check("d_unexpected", 64'(d_q.size()), 64'd1);
                else begin
                    e = d_q.pop_front();
                    check("d_resp", {32'(cyc), d_rdata}, e);
                end
            end else check("d_rdata_idle", {32'd0, d_rdata}, 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int first_if, n_if;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = pat(i);
            ref_mem[i] = pat(i);
        end
        // Requests driven during reset must not leak through.
        reset = 1'b1; reset3 = 1'b1;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h44; d_wdata = 32'hFFFF_FFFF;
        if_req3 = 1'b1; if_addr3 = 32'h20;
        repeat (2) tick();
        @(negedge clk);
        check("rst_ctl", {58'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}, 64'd0);
        check("rst_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        check("rst3_ctl", {61'd0, if_gnt3, mem_en3, if_rvalid3}, 64'd0);
        tick();
        reset = 1'b0; reset3 = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req3 = 1'b0;

        // Single fetch, zero grant latency.
        tick();
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check("t1_gnt", {62'd0, if_gnt, d_gnt}, 64'd2);
        check("t1_mem", {31'd0, mem_en, mem_addr}, {32'd1, 32'h10});
        tick();
        if_req = 1'b0;
        @(negedge clk);
        check("t1_rvalid", {63'd0, if_rvalid}, 64'd1);
        check("t1_rdata", {32'd0, if_rdata}, {32'd0, pat(4)});

        // Data beats fetch; fetch granted in the d_rvalid cycle.
        tick();
        if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        @(negedge clk);
        check("t2_gnt0", {62'd0, if_gnt, d_gnt}, 64'd1);
        check("t2_addr0", {32'd0, mem_addr}, 64'h200);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        check("t2_gnt1", {61'd0, if_gnt, d_gnt, d_rvalid}, 64'd5);
        check("t2_drdata", {32'd0, d_rdata}, {32'd0, pat(128)});
        check("t2_addr1", {32'd0, mem_addr}, 64'h8);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        check("t2_ifrv", {63'd0, if_rvalid}, 64'd1);

        // Write then read-back of the same word.
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t3_wr", {61'd0, d_gnt, mem_en, mem_we}, 64'd7);
        check("t3_wdata", {mem_addr, mem_wdata}, {32'h40, 32'hDEAD_BEEF});
        tick();
        d_we = 1'b0;
        @(negedge clk);
        check("t3_rd", {61'd0, d_gnt, mem_we, d_rvalid}, 64'd4);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        check("t3_rback", {31'd0, d_rvalid, d_rdata}, {32'd1, 32'hDEAD_BEEF});

        // Continuous contention: strict priority or starvation promotion.
        tick();
        if_req = 1'b1; if_addr = 32'hC; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        first_if = -1; n_if = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if_gnt) begin
                n_if++;
                if (first_if < 0) first_if = k;
            end
            tick();
        end
`ifdef ARB_STARVE_GUARD_EN
        check("t4_promote_cycle", 64'(first_if), 64'd4);
        check("t4_if_count", 64'(n_if), 64'd1);
`else
        check("t4_strict_prio", 64'(n_if), 64'd0);
`endif
        d_req = 1'b0;
        @(negedge clk);
        check("t4_if_after", {63'd0, if_gnt}, 64'd1);
        tick();
        if_req = 1'b0;

        // Latency-3 instance: reset during an outstanding read abandons it.
        tick();
        if_req3 = 1'b1; if_addr3 = 32'h20;
        @(negedge clk);
        check("t5_gnt", {62'd0, if_gnt3, mem_en3}, 64'd3);
        tick();
        if_req3 = 1'b0;
        @(negedge clk);
        check("t5_c1", {63'd0, if_rvalid3}, 64'd0);
        tick();
        reset3 = 1'b1;
        @(negedge clk);
        check("t5_c2", {61'd0, if_gnt3, if_rvalid3, mem_en3}, 64'd0);
        tick();
        reset3 = 1'b0;
        @(negedge clk);
        check("t5_c3", {31'd0, if_rvalid3, if_rdata3}, 64'd0);
        tick();
        @(negedge clk);
        check("t5_c4", {63'd0, if_rvalid3}, 64'd0);
        tick();
        if_req3 = 1'b1; if_addr3 = 32'h24;
        @(negedge clk);
        check("t5_idle_gnt", {31'd0, if_gnt3, mem_addr3}, {32'd1, 32'h24});
        tick();
        if_req3 = 1'b0;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            check("t5_lat_wait", {63'd0, if_rvalid3}, 64'd0);
            tick();
        end
        @(negedge clk);
        check("t5_lat3", {31'd0, if_rvalid3, if_rdata3}, {32'd1, MEM3_DATA});

        // Back-to-back fetches at one per cycle.
        tick();
        for (int k = 0; k < 8; k++) begin
            if_req = 1'b1; if_addr = 32'(4 * k);
            @(negedge clk);
            check("t6_gnt", {62'd0, if_gnt, if_rvalid}, {62'd0, 1'b1, (k > 0)});
            check("t6_addr", {32'd0, mem_addr}, 64'(4 * k));
            tick();
        end
        if_req = 1'b0;
        @(negedge clk);
        check("t6_last_rv", {31'd0, if_rvalid, if_rdata}, {32'd1, pat(7)});
        repeat (3) tick();
        check("if_q_drained", 64'(if_q.size()), 64'd0);
        check("d_q_drained", 64'(d_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
